// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtract sequencer.
package serial_sub_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width; at least one bit so WIDTH=1 still has a legal counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/done handshake and result bus of the serial subtractor.
// ZERO/OVF members exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (output start, opa, opb, bin,
                    input  ready, busy, done, diff, borrow, zero, ovf);
    modport slave  (input  start, opa, opb, bin,
                    output ready, busy, done, diff, borrow, zero, ovf);
`else
    modport master (output start, opa, opb, bin,
                    input  ready, busy, done, diff, borrow);
    modport slave  (input  start, opa, opb, bin,
                    output ready, busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub_ctrl_fullsub.sv
// One-bit full subtractor: D = A - B - B_I, B_O = borrow out.
module serial_sub_ctrl_fullsub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bi,
    output logic o_d,
    output logic o_bo
);
    assign o_d  = i_a ^ i_b ^ i_bi;
    assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial OPA - OPB - BIN sequencer, LSB first through one full-subtractor cell.
// Optional ZERO/OVF flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serial_sub_ctrl_if.slave   s_if
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_brw;
    logic             r_borrow;
    logic             r_done;

    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_d_next;

    serial_sub_ctrl_fullsub u_fullsub (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_bi (r_brw),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    // Shift the new difference bit in at the MSB; the cast drops the bit shifted out.
    assign w_d_next = WIDTH'({w_d, r_d_sr} >> 1);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    logic r_a_msb;
    logic r_b_msb;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_brw    <= 1'b0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_if.start) begin
                        r_a_sr  <= s_if.opa;
                        r_b_sr  <= s_if.opb;
                        r_brw   <= s_if.bin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        r_a_msb <= s_if.opa[WIDTH-1];
                        r_b_msb <= s_if.opb[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_d_sr <= w_d_next;
                    r_brw  <= w_bo;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= ST_IDLE;
                        r_diff   <= w_d_next;
                        r_borrow <= w_bo;
                        r_done   <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
                        r_zero   <= (w_d_next == '0);
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_d_next[WIDTH-1] != r_a_msb);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_if.ready  = (r_state == ST_IDLE);
    assign s_if.busy   = (r_state == ST_RUN);
    assign s_if.done   = r_done;
    assign s_if.diff   = r_diff;
    assign s_if.borrow = r_borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    assign s_if.zero   = r_zero;
    assign s_if.ovf    = r_ovf;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) against an arithmetic reference model.
// Flag checks are compiled in when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] prev_diff = '0;

    serial_sub_ctrl_if #(.WIDTH(W)) s_if ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (s_if)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction; negative result means a borrow out.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int r;
        r = int'(a) - int'(b) - int'(bi);
        return {(r < 0), r[W-1:0]};
    endfunction

    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                               input int n0, input string tag);
        logic [W:0]   exp;
        int           n;
        logic         seen, stable, busy_ok;
        exp = model(a, b, bi);
        n = n0; seen = 1'b0; stable = 1'b1; busy_ok = 1'b1;
        while (n < 4 * W && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (s_if.done === 1'b1) seen = 1'b1;
            else begin
                if (s_if.diff !== prev_diff) stable = 1'b0;
                if (s_if.busy !== 1'b1 || s_if.ready !== 1'b0) busy_ok = 1'b0;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done timeout after %0d edges", tag, n);
        end
        checks++;
        if (n !== W) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", tag, n, W);
        end
        checks++;
        if (!stable || !busy_ok) begin
            errors++;
            $display("FAIL %s run-phase stable=%0d busy_ok=%0d exp 1 1", tag, stable, busy_ok);
        end
        checks++;
        if (s_if.diff !== exp[W-1:0] || s_if.borrow !== exp[W]) begin
            errors++;
            $display("FAIL %s result got %h/%0d exp %h/%0d", tag, s_if.diff, s_if.borrow, exp[W-1:0], exp[W]);
        end
        checks++;
        if (s_if.ready !== 1'b1 || s_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done-cycle ready/busy got %0d/%0d exp 1/0", tag, s_if.ready, s_if.busy);
        end
`ifdef SERIAL_SUB_FLAGS_EN
        begin
            logic ez, eo;
            ez = (exp[W-1:0] == '0);
            eo = (a[W-1] != b[W-1]) && (exp[W-1] != a[W-1]);
            checks++;
            if (s_if.zero !== ez || s_if.ovf !== eo) begin
                errors++;
                $display("FAIL %s flags zero/ovf got %0d/%0d exp %0d/%0d", tag, s_if.zero, s_if.ovf, ez, eo);
            end
        end
`endif
        prev_diff = exp[W-1:0];
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input string tag);
        @(negedge clk);
        checks++;
        if (s_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready before start got %0d exp 1", tag, s_if.ready);
        end
        s_if.opa = a; s_if.opb = b; s_if.bin = bi; s_if.start = 1'b1;
        @(posedge clk);
        #1 s_if.start = 1'b0;
    endtask

    task automatic check_single_pulse(input string tag);
        @(negedge clk);
        checks++;
        if (s_if.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse width got done=%0d exp 0", tag, s_if.done);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input string tag);
        accept(a, b, bi, tag);
        wait_result(a, b, bi, 0, tag);
        check_single_pulse(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (s_if.ready !== 1'b1 || s_if.busy !== 1'b0 || s_if.done !== 1'b0 ||
            s_if.diff !== '0 || s_if.borrow !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy/busy/done/diff/brw got %0d/%0d/%0d/%h/%0d exp 1/0/0/00/0",
                     tag, s_if.ready, s_if.busy, s_if.done, s_if.diff, s_if.borrow);
        end
`ifdef SERIAL_SUB_FLAGS_EN
        checks++;
        if (s_if.zero !== 1'b0 || s_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s flags got %0d/%0d exp 0/0", tag, s_if.zero, s_if.ovf);
        end
`endif
    endtask

    task automatic test_reset();
        s_if.start = 1'b0; s_if.opa = '0; s_if.opb = '0; s_if.bin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        prev_diff = '0;
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h3C, 1'b0, "dir_5a_3c");
        run_op(8'h00, 8'h01, 1'b0, "dir_00_01");
        run_op(8'h10, 8'h0F, 1'b1, "dir_10_0f_b1");
        run_op(8'h80, 8'h01, 1'b0, "dir_80_01");
        run_op(8'hFF, 8'hFF, 1'b1, "dir_ff_ff_b1");
    endtask

    task automatic test_start_while_busy();
        accept(8'h5A, 8'h3C, 1'b0, "busy_start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_if.opa = 8'hFF; s_if.opb = 8'h00; s_if.bin = 1'b1; s_if.start = 1'b1;
        @(posedge clk);
        #1 s_if.start = 1'b0;
        wait_result(8'h5A, 8'h3C, 1'b0, 4, "busy_start");
        check_single_pulse("busy_start");
        repeat (W + 2) begin
            @(negedge clk);
            checks++;
            if (s_if.done !== 1'b0 || s_if.busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_start stray activity done/busy got %0d/%0d exp 0/0", s_if.done, s_if.busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic stray;
        accept(8'h33, 8'h11, 1'b0, "rst_mid");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        prev_diff = '0;
        stray = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (s_if.done !== 1'b0 || s_if.busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_mid activity after reset got stray=1 exp 0");
        end
        run_op(8'hC4, 8'h47, 1'b1, "rst_mid_fresh");
    endtask

    task automatic test_back_to_back();
        accept(8'h21, 8'h42, 1'b0, "b2b_first");
        wait_result(8'h21, 8'h42, 1'b0, 0, "b2b_first");
        // still in the DONE cycle (negedge): present the next request now
        s_if.opa = 8'h7E; s_if.opb = 8'h81; s_if.bin = 1'b1; s_if.start = 1'b1;
        @(posedge clk);
        #1 s_if.start = 1'b0;
        wait_result(8'h7E, 8'h81, 1'b1, 0, "b2b_second");
        check_single_pulse("b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         bi;
        for (int i = 0; i < 30; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            bi = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(a, b, bi, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
